lease_expiry_sampler_mc: RTL and testbench

- Multi-channel successor to the single-core lease tracker path.
- Samples each channel's per-block expired-lease flags every SAMPLE_PERIOD serviced requests.
- For each sample, reduces the flags to a popcount, tags it with the channel and request count, and queues the result in a shared sample FIFO.
- The FIFO is drained over the 32-bit comm port. stall_o throttles the cores when a sample would otherwise be lost.

---
 rtl/lease_expiry_sampler_mc.sv | 261 ++++++++++++++++++++++++++
 tb/tb_lease_expiry_sampler_mc.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lease_expiry_sampler_mc.sv
// ---------------------------------------------------------------------------
// lease_expiry_sampler_mc
//
// Purpose: each channel counts its serviced requests. Every `period` requests
// it reduces that channel's expired-lease flags to a popcount. The popcount is
// tagged with the channel index and the request count. The result goes to a
// per-channel 1-deep pending register and from there into a shared sample
// FIFO, which a host drains through a strobed 32-bit command port.
//
// Ports:
//   clock_i          : single clock, rising edge
//   reset_i          : asynchronous, active-high reset
//   enable_i         : tracking enable; low freezes counting and sampling
//   request_i        : per-channel one-cycle serviced-request pulse
//   expired_flags_i  : channel c at [c*CAP +: CAP], set bit = lease expired
//   comm_i           : [31] strobe, [30:28] opcode, [15:0] argument
//   comm_o           : registered command response
//   stall_o          : registered; any pending sample or FIFO full
//
// Sample entry layout: [31:28] channel, [27:16] request count, [15:0] popcount
// ---------------------------------------------------------------------------
module lease_expiry_sampler_mc #(
   parameter int CACHE_BLOCK_CAPACITY = 128,
   parameter int N_CHANNELS           = 2,
   parameter int SAMPLE_DEPTH         = 64,
   parameter int SAMPLE_PERIOD_RST    = 1
) (
   input  logic                                       clock_i,
   input  logic                                       reset_i,
   input  logic                                       enable_i,
   input  logic [N_CHANNELS-1:0]                      request_i,
   input  logic [N_CHANNELS*CACHE_BLOCK_CAPACITY-1:0] expired_flags_i,
   input  logic [31:0]                                comm_i,
   output logic [31:0]                                comm_o,
   output logic                                       stall_o
);

   localparam int CAP = CACHE_BLOCK_CAPACITY;
   localparam int NCH = N_CHANNELS;
   localparam int AW  = $clog2(SAMPLE_DEPTH);
   localparam int CW  = AW + 1;
   localparam logic [CW-1:0] DEPTH_C    = CW'(SAMPLE_DEPTH);
   localparam logic [15:0]   PERIOD_RST = 16'(SAMPLE_PERIOD_RST);

   typedef logic [31:0] entry_t;

   function automatic logic [15:0] popcount(input logic [CAP-1:0] v);
      logic [16:0] sum;
      sum = '0;
      for (int i = 0; i < CAP; i++) begin
         sum = sum + {16'b0, v[i]};
      end
      return sum[15:0];
   endfunction

   // command decode
   logic        strobe_q;
   logic        cmd_go;
   logic [2:0]  cmd_op;
   logic [15:0] cmd_arg;
   logic        cmd_pop;
   logic        cmd_clr;
   logic        cmd_per;

   // per-channel state
   logic [15:0]    period_q, period_d;
   logic [11:0]    req_cnt_q  [NCH];
   logic [11:0]    req_cnt_d  [NCH];
   logic [15:0]    phase_q    [NCH];
   logic [15:0]    phase_d    [NCH];
   logic [NCH-1:0] pend_vld_q, pend_vld_d;
   entry_t         pend_dat_q [NCH];
   entry_t         pend_dat_d [NCH];
   logic [NCH-1:0] req_hit;
   logic [NCH-1:0] sample_due;
   logic [NCH-1:0] grant;
   logic [NCH-1:0] drop;
   entry_t         sample_dat [NCH];

   // drop counter
   logic [15:0] drop_cnt_q, drop_cnt_d;
   logic [4:0]  n_drop;
   logic [16:0] drop_sum;

   // FIFO
   entry_t        mem [SAMPLE_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_wr;
   logic          pop_ok;
   logic          win_found;
   entry_t        win_dat;

   // outputs
   logic [31:0] comm_d;
   logic        stall_d;

   // Commands fire once, on the rising edge of the strobe.
   assign cmd_op  = comm_i[30:28];
   assign cmd_arg = comm_i[15:0];
   assign cmd_go  = comm_i[31] & ~strobe_q;
   assign cmd_pop = cmd_go & (cmd_op == 3'd1);
   assign cmd_clr = cmd_go & (cmd_op == 3'd4);
   assign cmd_per = cmd_go & (cmd_op == 3'd5);

   always_comb begin
      req_hit    = '0;
      sample_due = '0;
      for (int c = 0; c < NCH; c++) begin
         req_hit[c]    = enable_i & request_i[c];
         sample_due[c] = req_hit[c] & (phase_q[c] == (period_q - 16'd1));
         sample_dat[c] = {4'(c), req_cnt_q[c] + 12'd1,
                          popcount(expired_flags_i[c*CAP +: CAP])};
      end
   end

   // Lowest-indexed valid pending register wins the single FIFO write slot.
   // A pop in the same cycle frees a slot, so a full FIFO still accepts it.
   always_comb begin
      grant     = '0;
      win_found = 1'b0;
      win_dat   = '0;
      for (int c = 0; c < NCH; c++) begin
         if (pend_vld_q[c] && !win_found) begin
            win_found = 1'b1;
            grant[c]  = 1'b1;
            win_dat   = pend_dat_q[c];
         end
      end
      fifo_full  = (count_q == DEPTH_C);
      fifo_empty = (count_q == '0);
      pop_ok     = cmd_pop & ~fifo_empty;
      fifo_wr    = win_found & (~fifo_full | pop_ok) & ~cmd_clr;
   end

   // A sample is dropped only if its pending register stays occupied through
   // this edge, i.e. it is valid and not the one being written out now.
   always_comb begin
      drop   = '0;
      n_drop = '0;
      for (int c = 0; c < NCH; c++) begin
         req_cnt_d[c]  = req_cnt_q[c];
         phase_d[c]    = phase_q[c];
         pend_vld_d[c] = pend_vld_q[c];
         pend_dat_d[c] = pend_dat_q[c];
         drop[c]       = sample_due[c] & pend_vld_q[c] & ~(grant[c] & fifo_wr);

         if (req_hit[c]) begin
            req_cnt_d[c] = req_cnt_q[c] + 12'd1;
            phase_d[c]   = sample_due[c] ? 16'd0 : (phase_q[c] + 16'd1);
         end
         if (grant[c] & fifo_wr) begin
            pend_vld_d[c] = 1'b0;
         end
         if (sample_due[c] & ~drop[c]) begin
            pend_vld_d[c] = 1'b1;
            pend_dat_d[c] = sample_dat[c];
         end
         if (drop[c]) begin
            n_drop = n_drop + 5'd1;
         end
         if (cmd_per) begin
            phase_d[c] = '0;
         end
         if (cmd_clr) begin
            req_cnt_d[c]  = '0;
            phase_d[c]    = '0;
            pend_vld_d[c] = 1'b0;
            pend_dat_d[c] = '0;
         end
      end

      drop_sum = {1'b0, drop_cnt_q} + {12'b0, n_drop};
      if (cmd_clr) begin
         drop_cnt_d = '0;
      end else if (drop_sum[16]) begin
         drop_cnt_d = 16'hFFFF;
      end else begin
         drop_cnt_d = drop_sum[15:0];
      end

      period_d = period_q;
      if (cmd_per) begin
         period_d = (cmd_arg == 16'd0) ? 16'd1 : cmd_arg;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(fifo_wr);
      rd_ptr_d = rd_ptr_q + AW'(pop_ok);
      count_d  = count_q + CW'(fifo_wr) - CW'(pop_ok);
      if (cmd_clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_comb begin
      comm_d = comm_o;
      if (cmd_go) begin
         case (cmd_op)
            3'd1:    comm_d = fifo_empty ? 32'hFFFF_FFFF : mem[rd_ptr_q];
            3'd2:    comm_d = 32'(count_q);
            3'd3:    comm_d = {16'b0, drop_cnt_q};
            3'd4:    comm_d = '0;
            3'd5:    comm_d = {16'b0, period_d};
            3'd6,
            3'd7:    comm_d = 32'hDEAD_BEEF;
            default: comm_d = comm_o;
         endcase
      end
      // Reflects the state that this edge establishes.
      stall_d = (|pend_vld_d) | (count_d == DEPTH_C);
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         strobe_q   <= 1'b0;
         period_q   <= PERIOD_RST;
         pend_vld_q <= '0;
         drop_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         comm_o     <= '0;
         stall_o    <= 1'b0;
         for (int c = 0; c < NCH; c++) begin
            req_cnt_q[c]  <= '0;
            phase_q[c]    <= '0;
            pend_dat_q[c] <= '0;
         end
      end else begin
         strobe_q   <= comm_i[31];
         period_q   <= period_d;
         pend_vld_q <= pend_vld_d;
         drop_cnt_q <= drop_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         comm_o     <= comm_d;
         stall_o    <= stall_d;
         for (int c = 0; c < NCH; c++) begin
            req_cnt_q[c]  <= req_cnt_d[c];
            phase_q[c]    <= phase_d[c];
            pend_dat_q[c] <= pend_dat_d[c];
         end
      end
   end

   // Storage is not reset; the pointers and occupancy define visibility.
   always_ff @(posedge clock_i) begin
      if (fifo_wr) begin
         mem[wr_ptr_q] <= win_dat;
      end
   end

endmodule

// File: tb/tb_lease_expiry_sampler_mc.sv
module tb_lease_expiry_sampler_mc;

   localparam int CAP   = 128;
   localparam int NCH   = 2;
   localparam int DEPTH = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           en;
   logic [1:0]     req;
   logic [255:0]   flags;
   logic [31:0]    comm_in;
   logic [31:0]    comm_out;
   logic           stall;

   int checks = 0;
   int errors = 0;

   lease_expiry_sampler_mc #(
      .CACHE_BLOCK_CAPACITY(CAP),
      .N_CHANNELS(NCH),
      .SAMPLE_DEPTH(DEPTH),
      .SAMPLE_PERIOD_RST(1)
   ) dut (
      .clock_i(clk),
      .reset_i(rst),
      .enable_i(en),
      .request_i(req),
      .expired_flags_i(flags),
      .comm_i(comm_in),
      .comm_o(comm_out),
      .stall_o(stall)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   int            m_period;
   int            m_req   [NCH];
   int            m_phase [NCH];
   bit            m_pv    [NCH];
   logic [31:0]   m_pd    [NCH];
   logic [31:0]   m_q     [$];
   int            m_drops;
   logic [31:0]   m_comm;
   bit            m_stall;
   bit            m_prev;

   task automatic model_reset();
      m_period = 1;
      for (int c = 0; c < NCH; c++) begin
         m_req[c] = 0; m_phase[c] = 0; m_pv[c] = 0; m_pd[c] = '0;
      end
      m_q.delete();
      m_drops = 0; m_comm = '0; m_stall = 0; m_prev = 0;
   endtask

   task automatic model_step();
      bit          go;
      logic [2:0]  op;
      logic [15:0] arg;
      bit          popd;
      int          w;
      bit          due [NCH];
      logic [31:0] e;
      go  = comm_in[31] && !m_prev;
      m_prev = comm_in[31];
      op  = comm_in[30:28];
      arg = comm_in[15:0];
      if (go && op == 3'd4) begin
         for (int c = 0; c < NCH; c++) begin
            m_req[c] = 0; m_phase[c] = 0; m_pv[c] = 0;
         end
         m_q.delete();
         m_drops = 0; m_comm = '0; m_stall = 0;
         return;
      end
      for (int c = 0; c < NCH; c++)
         due[c] = en && req[c] && (m_phase[c] == m_period - 1);
      if (go) begin
         case (op)
            3'd1: m_comm = (m_q.size() > 0) ? m_q[0] : 32'hFFFF_FFFF;
            3'd2: m_comm = 32'(m_q.size());
            3'd3: m_comm = 32'(m_drops);
            3'd5: m_comm = (arg == 16'd0) ? 32'd1 : {16'b0, arg};
            3'd6, 3'd7: m_comm = 32'hDEAD_BEEF;
            default: ;
         endcase
      end
      popd = go && op == 3'd1 && m_q.size() > 0;
      w = -1;
      for (int c = 0; c < NCH; c++) if (m_pv[c] && w < 0) w = c;
      if (popd) void'(m_q.pop_front());
      if (w >= 0 && m_q.size() < DEPTH) begin
         m_q.push_back(m_pd[w]);
         m_pv[w] = 0;
      end
      for (int c = 0; c < NCH; c++) begin
         if (en && req[c]) begin
            m_req[c] = (m_req[c] + 1) % 4096;
            if (due[c]) begin
               e = {4'(c), 12'(m_req[c]), 16'($countones(flags[c*CAP +: CAP]))};
               if (m_pv[c]) begin
                  if (m_drops < 65535) m_drops++;
               end else begin
                  m_pv[c] = 1; m_pd[c] = e;
               end
               m_phase[c] = 0;
            end else begin
               m_phase[c] = m_phase[c] + 1;
            end
         end
      end
      if (go && op == 3'd5) begin
         m_period = (arg == 16'd0) ? 1 : int'(arg);
         for (int c = 0; c < NCH; c++) m_phase[c] = 0;
      end
      m_stall = m_pv[0] || m_pv[1] || (m_q.size() == DEPTH);
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("comm_o_model", comm_out, m_comm);
      chk("stall_o_model", {31'b0, stall}, {31'b0, m_stall});
   endtask

   task automatic cmd(input logic [2:0] op, input logic [15:0] arg);
      comm_in = {1'b1, op, 12'b0, arg};
      tick();
      comm_in = '0;
      tick();
   endtask

   task automatic pulse(input logic [1:0] r);
      req = r;
      tick();
      req = '0;
      tick();
   endtask

   task automatic rand_flags();
      for (int i = 0; i < 8; i++) flags[i*32 +: 32] = $urandom();
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [15:0] arg;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [10];

   initial begin
      logic [31:0] expv;
      int          stall_cycles;

      vecs[0] = '{3'd2, 16'd0, 32'h0000_0000};
      vecs[1] = '{3'd3, 16'd0, 32'h0000_0000};
      vecs[2] = '{3'd1, 16'd0, 32'hFFFF_FFFF};
      vecs[3] = '{3'd0, 16'd0, 32'hFFFF_FFFF};
      vecs[4] = '{3'd6, 16'd0, 32'hDEAD_BEEF};
      vecs[5] = '{3'd7, 16'd0, 32'hDEAD_BEEF};
      vecs[6] = '{3'd5, 16'd0, 32'h0000_0001};
      vecs[7] = '{3'd5, 16'd7, 32'h0000_0007};
      vecs[8] = '{3'd5, 16'd1, 32'h0000_0001};
      vecs[9] = '{3'd4, 16'd0, 32'h0000_0000};

      rst = 1'b1; en = 1'b1; req = '0; flags = '0; comm_in = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_comm_o", comm_out, 32'h0);
      chk("reset_stall_o", {31'b0, stall}, 32'h0);
      rst = 1'b0;

      // command table
      for (int i = 0; i < 10; i++) begin
         cmd(vecs[i].op, vecs[i].arg);
         chk($sformatf("vec%0d", i), comm_out, vecs[i].exp);
      end

      // basic sampling
      flags = '0;
      flags[3] = 1; flags[10] = 1; flags[50] = 1; flags[90] = 1; flags[127] = 1;
      pulse(2'b01);
      cmd(3'd1, 16'd0);
      chk("basic_pop", comm_out, 32'h0001_0005);

      // period change
      cmd(3'd4, 16'd0);
      cmd(3'd5, 16'd4);
      flags = '0;
      flags[128] = 1; flags[133] = 1; flags[228] = 1;
      for (int i = 0; i < 8; i++) pulse(2'b10);
      cmd(3'd2, 16'd0);
      chk("period_occ", comm_out, 32'd2);
      cmd(3'd1, 16'd0);
      chk("period_pop0", comm_out, 32'h1004_0003);
      cmd(3'd1, 16'd0);
      chk("period_pop1", comm_out, 32'h1008_0003);

      // simultaneous samples
      cmd(3'd4, 16'd0);
      cmd(3'd5, 16'd1);
      req = 2'b11;
      tick();
      req = '0;
      stall_cycles = stall ? 1 : 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (stall) stall_cycles++;
      end
      chk("simul_stall_cycles", 32'(stall_cycles), 32'd2);
      cmd(3'd3, 16'd0);
      chk("simul_drops", comm_out, 32'd0);
      cmd(3'd1, 16'd0);
      chk("simul_first_ch", {28'b0, comm_out[31:28]}, 32'd0);
      cmd(3'd1, 16'd0);
      chk("simul_second_ch", {28'b0, comm_out[31:28]}, 32'd1);

      // full and drop
      cmd(3'd4, 16'd0);
      flags = '0;
      for (int i = 0; i < 4; i++) pulse(2'b01);
      chk("full_stall", {31'b0, stall}, 32'd1);
      cmd(3'd2, 16'd0);
      chk("full_occ", comm_out, 32'd4);
      pulse(2'b01);
      pulse(2'b01);
      cmd(3'd3, 16'd0);
      chk("full_drops", comm_out, 32'd1);
      cmd(3'd1, 16'd0);
      chk("full_pop", comm_out, 32'h0001_0000);
      cmd(3'd2, 16'd0);
      chk("full_occ_after_pop", comm_out, 32'd4);

      // clear with a pending entry
      pulse(2'b01);
      comm_in = {1'b1, 3'd4, 28'b0};
      tick();
      chk("clear_stall", {31'b0, stall}, 32'd0);
      comm_in = '0;
      tick();
      cmd(3'd2, 16'd0);
      chk("clear_occ", comm_out, 32'd0);
      cmd(3'd3, 16'd0);
      chk("clear_drops", comm_out, 32'd0);

      // wrap and empty
      cmd(3'd5, 16'd1);
      for (int i = 0; i < 10; i++) begin
         rand_flags();
         expv = {4'd0, 12'(i + 1), 16'($countones(flags[CAP-1:0]))};
         pulse(2'b01);
         cmd(3'd1, 16'd0);
         chk($sformatf("wrap_pop%0d", i), comm_out, expv);
      end
      cmd(3'd1, 16'd0);
      chk("empty_pop", comm_out, 32'hFFFF_FFFF);

      // request count wrap: single sample on request 4097
      cmd(3'd4, 16'd0);
      cmd(3'd5, 16'd4097);
      flags = '0;
      flags[6:0] = 7'h7F;
      req = 2'b01;
      for (int i = 0; i < 4097; i++) tick();
      req = '0;
      tick();
      cmd(3'd1, 16'd0);
      chk("count_wrap", comm_out, 32'h0001_0007);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic [2:0] op;
         en  = ($urandom_range(0, 9) != 0);
         req = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) rand_flags();
         if (comm_in[31]) begin
            comm_in = '0;
         end else if ($urandom_range(0, 2) == 0) begin
            op = 3'($urandom_range(0, 7));
            if (op == 3'd4 && $urandom_range(0, 7) != 0) op = 3'd1;
            if ($urandom_range(0, 1) == 0) op = 3'd1;
            comm_in = {1'b1, op, 12'b0, 16'($urandom_range(0, 3))};
         end
         tick();
      end
      comm_in = '0; req = '0; en = 1'b1;
      tick();

      // reset mid-stream
      for (int i = 0; i < 4; i++) pulse(2'b11);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_comm_o", comm_out, 32'h0);
      chk("midrst_stall_o", {31'b0, stall}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("midrst_hold_comm_o", comm_out, 32'h0);
      chk("midrst_hold_stall_o", {31'b0, stall}, 32'h0);
      rst = 1'b0;
      model_reset();
      cmd(3'd2, 16'd0);
      chk("midrst_occ", comm_out, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
